// File: rtl/alu_control_word_decoder_pkg.sv
// Shared definitions for the 55-bit ALU control word: field positions, word width, decoder FSM states.
// Ports: none (package).
// Both the control-store encoder and the decoder take their field layout from here.
package alu_ctl_pkg;

  localparam int CW_WIDTH = 55;

  // Field bit positions inside the packed control word (MSB/LSB per field).
  localparam int PCI_BIT      = 54;
  localparam int OP_MSB       = 53;
  localparam int OP_LSB       = 50;
  localparam int A_ALT_MSB    = 49;
  localparam int A_ALT_LSB    = 34;
  localparam int B_ALT_MSB    = 33;
  localparam int B_ALT_LSB    = 18;
  localparam int A_SEL_MSB    = 17;
  localparam int A_SEL_LSB    = 14;
  localparam int B_SEL_MSB    = 13;
  localparam int B_SEL_LSB    = 10;
  localparam int A_SRC_BIT    = 9;
  localparam int B_SRC_BIT    = 8;
  localparam int OUT_SEL_MSB  = 7;
  localparam int OUT_SEL_LSB  = 4;
  localparam int LOAD_SRC_MSB = 3;
  localparam int LOAD_SRC_LSB = 2;
  localparam int ST_MEM_BIT   = 1;
  localparam int ST_STK_BIT   = 0;

  // Output stage states.
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_SINGLE  = 2'd1,
    ST_SPLIT_A = 2'd2,
    ST_SPLIT_B = 2'd3
  } dec_state_e;

  // A word needing both the memory and the stack store port.
  function automatic logic is_dual_store(input logic [CW_WIDTH-1:0] w);
    return w[ST_MEM_BIT] & w[ST_STK_BIT];
  endfunction

endpackage

// File: rtl/ctl_word_fifo.sv
// DEPTH x WIDTH synchronous FIFO with registered full/empty flags and wrap-bit pointers.
// Ports: i_push/i_push_dat write side, i_pop/o_head_dat show-ahead read side, o_full/o_empty flags.
// Pushes while full and pops while empty are ignored; push and pop may occur in the same cycle.
module ctl_word_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 55
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_full;
  logic             r_empty;

  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_wr_nxt;
  logic [AW:0]      w_rd_nxt;

  assign w_push   = i_push & ~r_full;
  assign w_pop    = i_pop & ~r_empty;
  assign w_wr_nxt = r_wr_ptr + {{AW{1'b0}}, w_push};
  assign w_rd_nxt = r_rd_ptr + {{AW{1'b0}}, w_pop};

  // Flags are registered from the next pointers so consumers see no
  // combinational path from the pop side to the full flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_full   <= (w_wr_nxt[AW] != w_rd_nxt[AW]) &&
                  (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);
      r_empty  <= (w_wr_nxt == w_rd_nxt);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end
  end

  assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full     = r_full;
  assign o_empty    = r_empty;

endmodule

// File: rtl/alu_control_word_decoder.sv
// Buffers packed ALU control words and presents registered decoded fields, one beat per output transfer.
// Ports: in_valid/in_ready/control_word input handshake; out_valid/out_ready plus decoded fields, out_first/out_last.
// Dual-store words are issued as two beats (memory store, then stack store) when SPLIT_DUAL_STORE is set.
module alu_control_word_decoder
  import alu_ctl_pkg::*;
#(
  parameter int DEPTH            = 2,
  parameter bit SPLIT_DUAL_STORE = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [CW_WIDTH-1:0]              control_word,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             program_counter_increment,
  output logic [OP_MSB-OP_LSB:0]           alu_op,
  output logic [A_ALT_MSB-A_ALT_LSB:0]     alu_a_altern,
  output logic [B_ALT_MSB-B_ALT_LSB:0]     alu_b_altern,
  output logic [A_SEL_MSB-A_SEL_LSB:0]     alu_a_select,
  output logic [B_SEL_MSB-B_SEL_LSB:0]     alu_b_select,
  output logic                             alu_a_source,
  output logic                             alu_b_source,
  output logic [OUT_SEL_MSB-OUT_SEL_LSB:0] alu_out_select,
  output logic [LOAD_SRC_MSB-LOAD_SRC_LSB:0] alu_load_src,
  output logic                             alu_store_to_mem,
  output logic                             alu_store_to_stk,
  output logic                             out_first,
  output logic                             out_last
);

  logic                w_full;
  logic                w_empty;
  logic [CW_WIDTH-1:0] w_head;
  logic                w_pop;
  logic                w_load;
  logic                w_out_xfer;

  dec_state_e          r_state;
  dec_state_e          w_state_nxt;
  logic [CW_WIDTH-1:0] r_out;
  logic [CW_WIDTH-1:0] w_out_nxt;
  logic                r_first;
  logic                w_first_nxt;
  logic                r_last;
  logic                w_last_nxt;
  logic                r_pend_pci;
  logic                w_pend_pci_nxt;

  ctl_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CW_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (in_valid),
    .i_push_dat (control_word),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign in_ready   = ~w_full;
  assign out_valid  = (r_state != ST_EMPTY);
  assign w_out_xfer = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_out      <= '0;
      r_first    <= 1'b0;
      r_last     <= 1'b0;
      r_pend_pci <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_out      <= w_out_nxt;
      r_first    <= w_first_nxt;
      r_last     <= w_last_nxt;
      r_pend_pci <= w_pend_pci_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_out_nxt      = r_out;
    w_first_nxt    = r_first;
    w_last_nxt     = r_last;
    w_pend_pci_nxt = r_pend_pci;
    w_load         = 1'b0;
    w_pop          = 1'b0;

    case (r_state)
      ST_EMPTY: begin
        w_load = ~w_empty;
      end
      ST_SINGLE, ST_SPLIT_B: begin
        if (w_out_xfer) begin
          if (!w_empty) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end
      end
      ST_SPLIT_A: begin
        // Second beat reuses the held word; the PC step deferred from
        // the first beat is restored here so it happens once per word.
        if (w_out_xfer) begin
          w_state_nxt            = ST_SPLIT_B;
          w_out_nxt[ST_MEM_BIT]  = 1'b0;
          w_out_nxt[ST_STK_BIT]  = 1'b1;
          w_out_nxt[PCI_BIT]     = r_pend_pci;
          w_first_nxt            = 1'b0;
          w_last_nxt             = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase

    if (w_load) begin
      w_pop          = 1'b1;
      w_out_nxt      = w_head;
      w_pend_pci_nxt = w_head[PCI_BIT];
      if (SPLIT_DUAL_STORE && is_dual_store(w_head)) begin
        w_state_nxt           = ST_SPLIT_A;
        w_out_nxt[ST_STK_BIT] = 1'b0;
        w_out_nxt[PCI_BIT]    = 1'b0;
        w_first_nxt           = 1'b1;
        w_last_nxt            = 1'b0;
      end else begin
        w_state_nxt = ST_SINGLE;
        w_first_nxt = 1'b1;
        w_last_nxt  = 1'b1;
      end
    end
  end

  assign program_counter_increment = r_out[PCI_BIT];
  assign alu_op                    = r_out[OP_MSB:OP_LSB];
  assign alu_a_altern              = r_out[A_ALT_MSB:A_ALT_LSB];
  assign alu_b_altern              = r_out[B_ALT_MSB:B_ALT_LSB];
  assign alu_a_select              = r_out[A_SEL_MSB:A_SEL_LSB];
  assign alu_b_select              = r_out[B_SEL_MSB:B_SEL_LSB];
  assign alu_a_source              = r_out[A_SRC_BIT];
  assign alu_b_source              = r_out[B_SRC_BIT];
  assign alu_out_select            = r_out[OUT_SEL_MSB:OUT_SEL_LSB];
  assign alu_load_src              = r_out[LOAD_SRC_MSB:LOAD_SRC_LSB];
  assign alu_store_to_mem          = r_out[ST_MEM_BIT];
  assign alu_store_to_stk          = r_out[ST_STK_BIT];
  assign out_first                 = r_first;
  assign out_last                  = r_last;

endmodule

// File: tb/tb_alu_control_word_decoder.sv
module tb_alu_control_word_decoder;

  typedef struct packed {
    logic        pci;
    logic [3:0]  op;
    logic [15:0] a_alt;
    logic [15:0] b_alt;
    logic [3:0]  a_sel;
    logic [3:0]  b_sel;
    logic        a_src;
    logic        b_src;
    logic [3:0]  out_sel;
    logic [1:0]  load_src;
    logic        st_mem;
    logic        st_stk;
  } fld_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [54:0] control_word;

  logic        d_in_ready, d_out_valid, d_pci, d_a_src, d_b_src, d_st_mem, d_st_stk, d_first, d_last;
  logic [3:0]  d_op, d_a_sel, d_b_sel, d_out_sel;
  logic [15:0] d_a_alt, d_b_alt;
  logic [1:0]  d_load_src;

  logic        n_in_ready, n_out_valid, n_pci, n_a_src, n_b_src, n_st_mem, n_st_stk, n_first, n_last;
  logic [3:0]  n_op, n_a_sel, n_b_sel, n_out_sel;
  logic [15:0] n_a_alt, n_b_alt;
  logic [1:0]  n_load_src;

  always #5 clk = ~clk;

  alu_control_word_decoder #(.DEPTH(2), .SPLIT_DUAL_STORE(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_in_ready), .control_word(control_word),
    .out_valid(d_out_valid), .out_ready(out_ready), .program_counter_increment(d_pci),
    .alu_op(d_op), .alu_a_altern(d_a_alt), .alu_b_altern(d_b_alt), .alu_a_select(d_a_sel),
    .alu_b_select(d_b_sel), .alu_a_source(d_a_src), .alu_b_source(d_b_src),
    .alu_out_select(d_out_sel), .alu_load_src(d_load_src), .alu_store_to_mem(d_st_mem),
    .alu_store_to_stk(d_st_stk), .out_first(d_first), .out_last(d_last)
  );

  alu_control_word_decoder #(.DEPTH(2), .SPLIT_DUAL_STORE(1'b0)) u_nosplit (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready), .control_word(control_word),
    .out_valid(n_out_valid), .out_ready(out_ready), .program_counter_increment(n_pci),
    .alu_op(n_op), .alu_a_altern(n_a_alt), .alu_b_altern(n_b_alt), .alu_a_select(n_a_sel),
    .alu_b_select(n_b_sel), .alu_a_source(n_a_src), .alu_b_source(n_b_src),
    .alu_out_select(n_out_sel), .alu_load_src(n_load_src), .alu_store_to_mem(n_st_mem),
    .alu_store_to_stk(n_st_stk), .out_first(n_first), .out_last(n_last)
  );

  // Expected beats: {fields, first, last}
  logic [56:0] q1[$];
  logic [56:0] q2[$];
  int checks = 0;
  int errors = 0;
  int n_in = 0;
  int n_out = 0;
  int n2_out = 0;
  bit chk2 = 1'b0;
  bit in_fired = 1'b0;

  function automatic logic [56:0] obs1();
    return {d_pci, d_op, d_a_alt, d_b_alt, d_a_sel, d_b_sel, d_a_src, d_b_src,
            d_out_sel, d_load_src, d_st_mem, d_st_stk, d_first, d_last};
  endfunction

  function automatic logic [56:0] obs2();
    return {n_pci, n_op, n_a_alt, n_b_alt, n_a_sel, n_b_sel, n_a_src, n_b_src,
            n_out_sel, n_load_src, n_st_mem, n_st_stk, n_first, n_last};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: one beat per word, or two beats when both stores are requested
  // (memory store first without PC step, then stack store carrying the PC step).
  task automatic model_accept(input fld_t f);
    fld_t a;
    fld_t b;
    if (f.st_mem && f.st_stk) begin
      a = f; a.st_stk = 1'b0; a.pci = 1'b0;
      b = f; b.st_mem = 1'b0; b.st_stk = 1'b1;
      q1.push_back({a, 2'b10});
      q1.push_back({b, 2'b01});
    end else begin
      q1.push_back({f, 2'b11});
    end
  endtask

  // Evaluate one cycle at the falling edge, then advance past the rising edge.
  task automatic step();
    @(negedge clk);
    if (d_out_valid) begin
      if (q1.size() == 0) chk("stray_beat", {63'd0, d_out_valid}, 64'd0);
      else chk("beat", {7'd0, obs1()}, {7'd0, q1[0]});
      if (out_ready && q1.size() != 0) begin
        void'(q1.pop_front());
        n_out++;
      end
    end
    if (chk2 && n_out_valid) begin
      if (q2.size() == 0) chk("stray_beat_nosplit", {63'd0, n_out_valid}, 64'd0);
      else chk("beat_nosplit", {7'd0, obs2()}, {7'd0, q2[0]});
      if (out_ready && q2.size() != 0) begin
        void'(q2.pop_front());
        n2_out++;
      end
    end
    in_fired = in_valid && d_in_ready;
    if (in_fired) begin
      model_accept(fld_t'(control_word));
      n_in++;
    end
    if (chk2 && in_valid && n_in_ready) q2.push_back({control_word, 2'b11});
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((q1.size() != 0 || (chk2 && q2.size() != 0)) && c < budget) begin
      step();
      c++;
    end
    chk("drain_left", q1.size(), 0);
    if (chk2) chk("drain_left_nosplit", q2.size(), 0);
    step();
  endtask

  function automatic fld_t rand_fld();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return fld_t'(r[54:0]);
  endfunction

  initial begin
    fld_t f;
    int base_in;
    int base_out;
    int base2;
    int sent;
    int cyc;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    control_word = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, d_in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, d_out_valid}, 64'd0);
    chk("rst_fields", {7'd0, obs1()}, 64'd0);
    rst = 1'b0;

    // Single-word round trip with 2-cycle latency.
    out_ready = 1'b1;
    in_valid = 1'b1;
    control_word = 55'h7F_FFFF_FFFF_FFFC;
    step();
    in_valid = 1'b0;
    chk("lat_not_1", {63'd0, d_out_valid}, 64'd0);
    step();
    chk("lat_2_valid", {63'd0, d_out_valid}, 64'd1);
    chk("rt_a_alt", {48'd0, d_a_alt}, 64'hFFFF);
    chk("rt_out_sel", {60'd0, d_out_sel}, 64'hF);
    chk("rt_first_last", {62'd0, d_first, d_last}, 64'd3);
    chk("rt_stores", {62'd0, d_st_mem, d_st_stk}, 64'd0);
    drain(20);

    // Dual-store split, with the non-splitting instance watched alongside.
    chk2 = 1'b1;
    base_out = n_out;
    base2 = n2_out;
    f = rand_fld();
    f.st_mem = 1'b1; f.st_stk = 1'b1; f.pci = 1'b1;
    control_word = f;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    drain(20);
    chk("split_beats", n_out - base_out, 2);
    chk("nosplit_beats", n2_out - base2, 1);
    chk2 = 1'b0;

    // Backpressure: 4 offered, 3 accepted.
    out_ready = 1'b0;
    base_in = n_in;
    base_out = n_out;
    for (int k = 0; k < 4; k++) begin
      f = rand_fld(); f.st_stk = 1'b0;
      control_word = f;
      in_valid = 1'b1;
      chk("full_in_ready", {63'd0, d_in_ready}, (k < 3) ? 64'd1 : 64'd0);
      step();
    end
    in_valid = 1'b0;
    chk("accepted_3", n_in - base_in, 3);
    drain(20);
    chk("released_3", n_out - base_out, 3);

    // Push and pop around a full buffer.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      f = rand_fld(); f.st_mem = 1'b0;
      control_word = f;
      in_valid = 1'b1;
      step();
    end
    f = rand_fld(); f.st_mem = 1'b0;
    control_word = f;
    out_ready = 1'b1;
    chk("full_blocks", {63'd0, d_in_ready}, 64'd0);
    step();
    chk("ready_recovers", {63'd0, d_in_ready}, 64'd1);
    step();
    chk("w4_taken", {63'd0, in_fired}, 64'd1);
    for (int k = 0; k < 2; k++) begin
      f = rand_fld();
      control_word = f;
      chk("pushpop_ready", {63'd0, d_in_ready}, 64'd1);
      step();
    end
    in_valid = 1'b0;
    drain(30);

    // Reset while the first beat of a split word waits and two words are buffered.
    out_ready = 1'b0;
    f = rand_fld(); f.st_mem = 1'b1; f.st_stk = 1'b1;
    control_word = f;
    in_valid = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      control_word = rand_fld();
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_split_a", {61'd0, d_out_valid, d_first, d_last}, 64'd6);
    chk("pre_rst_full", {63'd0, d_in_ready}, 64'd0);
    rst = 1'b1;
    step();
    q1.delete();
    chk("mid_rst_out_valid", {63'd0, d_out_valid}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, d_in_ready}, 64'd1);
    chk("mid_rst_fields", {7'd0, obs1()}, 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("post_rst_quiet", {63'd0, d_out_valid}, 64'd0);
    end

    // Randomised words and backpressure against the reference.
    base_out = n_out;
    sent = 0;
    cyc = 0;
    in_valid = 1'b0;
    in_fired = 1'b0;
    while (sent < 10000 && cyc < 60000) begin
      if (!in_valid || in_fired) begin
        in_valid = ($urandom_range(0, 9) < 8);
        control_word = rand_fld();
      end
      out_ready = ($urandom_range(0, 9) < 7);
      step();
      cyc++;
      if (in_fired) sent++;
    end
    in_valid = 1'b0;
    chk("rand_sent", sent, 10000);
    drain(200);
    chk("rand_beats_min", {63'd0, (n_out - base_out) >= 10000}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
